// File: rtl/cascade_tap_sequencer.sv
// Tap sequencer that drives a thermometer select onto a delay cascade and changes it only while line_in is quiet.
// Optional sweep mode (taps 0..6 with a launch pulse per tap) is built when CASCADE_SWEEP_EN is defined.
module cascade_tap_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned QUIET_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_tap,
  input  logic       line_in,
  input  logic       sweep_start,
  output logic [5:0] select,
  output logic       launch,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, and a same-cycle sweep_start wins.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_QUIET = 3'd1,
    APPLY      = 3'd2,
    SETTLE     = 3'd3,
`ifdef CASCADE_SWEEP_EN
    LAUNCH     = 3'd4,
`endif
    DONE       = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] quiet_cnt;
  logic [7:0] settle_cnt;
  logic [2:0] tap;
  logic       sweep_go;
  logic       accept;
  logic       quiet_ok;
  logic       settle_last;

`ifdef CASCADE_SWEEP_EN
  logic       sweep_mode;
  assign sweep_go = (state == IDLE) && sweep_start;
  assign launch   = (state == LAUNCH);
`else
  logic       unused_sweep_start;
  assign unused_sweep_start = sweep_start;
  assign sweep_go = 1'b0;
  assign launch   = 1'b0;
`endif

  assign req_ready   = (state == IDLE) && !rst;
  assign accept      = req_valid && req_ready && !sweep_go;
  assign quiet_ok    = (quiet_cnt == 4'(QUIET_CYCLES));
  assign settle_last = (settle_cnt == 8'(SETTLE_CYCLES - 1));
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (sweep_go || accept) state_next = WAIT_QUIET;
      WAIT_QUIET: if (quiet_ok) state_next = APPLY;
      APPLY:      state_next = SETTLE;
      SETTLE: begin
        if (settle_last) begin
`ifdef CASCADE_SWEEP_EN
          state_next = sweep_mode ? LAUNCH : DONE;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef CASCADE_SWEEP_EN
      LAUNCH:     state_next = (tap == 3'd6) ? DONE : WAIT_QUIET;
`endif
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      quiet_cnt  <= '0;
      settle_cnt <= '0;
      tap        <= '0;
      select     <= '0;
      err        <= 1'b0;
`ifdef CASCADE_SWEEP_EN
      sweep_mode <= 1'b0;
`endif
    end else begin
      state <= state_next;

      if (line_in)
        quiet_cnt <= '0;
      else if (!quiet_ok)
        quiet_cnt <= quiet_cnt + 4'd1;

      // Out-of-range taps clamp to the last stage and flag err until a legal request arrives.
      if (accept) begin
        tap <= (req_tap > 3'd6) ? 3'd6 : req_tap;
        err <= (req_tap > 3'd6);
`ifdef CASCADE_SWEEP_EN
        sweep_mode <= 1'b0;
`endif
      end

`ifdef CASCADE_SWEEP_EN
      if (sweep_go) begin
        tap        <= 3'd0;
        sweep_mode <= 1'b1;
      end
      if (state == LAUNCH && tap != 3'd6)
        tap <= tap + 3'd1;
`endif

      if (state == APPLY) begin
        select     <= 6'((7'd1 << tap) - 7'd1);
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cascade_tap_sequencer.sv
// Self-checking bench for cascade_tap_sequencer; exercises the sweep path when CASCADE_SWEEP_EN is defined.
module tb_cascade_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_tap = 3'd0;
  logic       line_in = 1'b0;
  logic       sweep_start = 1'b0;
  logic [5:0] select;
  logic       launch;
  logic       busy;
  logic       done;
  logic       err;

  int error_cnt = 0;
  int check_cnt = 0;
  int done_cnt = 0;
  int launch_cnt = 0;

  // Expected {err, select} at each done pulse.
  logic [6:0] exp_q[$];
  logic [5:0] thermo_tab[7] = '{6'h00, 6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F};

  cascade_tap_sequencer #(.SETTLE_CYCLES(4), .QUIET_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tap(req_tap), .line_in(line_in), .sweep_start(sweep_start),
    .select(select), .launch(launch), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(done_cnt - start), 32'd1);
    step();
  endtask

  // Scoreboard/monitor samples 1 time unit after the edge, ahead of the driver.
  always @(posedge clk) begin
    logic [6:0] e;
    #1;
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("done_result", 32'({err, select}), 32'(e));
      end
    end
    if (!rst && launch) begin
      if (launch_cnt < 7)
        check("launch_select", 32'(select), 32'(thermo_tab[launch_cnt]));
      else
        check("launch_count_over", 32'(launch_cnt), 32'd6);
      launch_cnt++;
    end
  end

  initial begin
    int start;
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_select", 32'(select), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Request tap 3, quiet line: exact latency
    req_valid = 1'b1;
    req_tap = 3'd3;
    check("t3_ready", 32'(req_ready), 32'd1);
    exp_q.push_back({1'b0, 6'h07});
    step();
    req_valid = 1'b0;
    check("t3_busy_e0", 32'(busy), 32'd1);
    check("t3_sel_e0", 32'(select), 32'h00);
    step();
    check("t3_sel_e1", 32'(select), 32'h00);
    step();
    check("t3_sel_e2", 32'(select), 32'h07);
    for (int i = 3; i < 6; i++) begin
      step();
      check("t3_done_early", 32'(done), 32'd0);
    end
    step();
    check("t3_done_e6", 32'(done), 32'd1);
    step();
    check("t3_done_e7", 32'(done), 32'd0);
    check("t3_ready_e7", 32'(req_ready), 32'd1);

    // Request tap 5 while line_in toggles
    req_valid = 1'b1;
    req_tap = 3'd5;
    line_in = 1'b1;
    exp_q.push_back({1'b0, 6'h1F});
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      line_in = i[0];
      step();
      check("t5_hold_toggle", 32'(select), 32'h07);
    end
    line_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_quiet", 32'(select), 32'h07);
    end
    step();
    check("t5_apply", 32'(select), 32'h1F);
    wait_done("t5_done", 30);

    // Out-of-range tap clamps and sets err; legal tap clears it
    req_valid = 1'b1;
    req_tap = 3'd7;
    exp_q.push_back({1'b1, 6'h3F});
    step();
    req_valid = 1'b0;
    check("t7_err_set", 32'(err), 32'd1);
    wait_done("t7_done", 30);
    req_valid = 1'b1;
    req_tap = 3'd1;
    exp_q.push_back({1'b0, 6'h01});
    step();
    req_valid = 1'b0;
    check("t1_err_clr", 32'(err), 32'd0);
    wait_done("t1_done", 30);

    for (int k = 0; k < 4; k++) begin
      req_tap = 3'($urandom_range(0, 6));
      req_valid = 1'b1;
      exp_q.push_back({1'b0, thermo_tab[req_tap]});
      step();
      req_valid = 1'b0;
      wait_done("rand_done", 30);
    end

`ifdef CASCADE_SWEEP_EN
    // Sweep wins over a same-cycle request; the request is held off, then served
    launch_cnt = 0;
    exp_q.push_back({1'b0, 6'h3F});
    exp_q.push_back({1'b0, 6'h03});
    sweep_start = 1'b1;
    req_valid = 1'b1;
    req_tap = 3'd2;
    step();
    sweep_start = 1'b0;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 200) begin
      check("sweep_ready_low", 32'(req_ready), 32'd0);
      step();
      n++;
    end
    check("sweep_done_seen", 32'(done_cnt - start), 32'd1);
    check("sweep_launches", 32'(launch_cnt), 32'd7);
    step();
    check("post_sweep_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    wait_done("held_req_done", 30);

    // Reset during SETTLE at tap 4 aborts with no done pulse
    launch_cnt = 0;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    n = 0;
    while (launch_cnt < 4 && n < 200) begin
      step();
      n++;
    end
    check("abort_reach_tap4", 32'(launch_cnt), 32'd4);
    repeat (3) step();
    check("abort_settle_sel", 32'(select), 32'h0F);
    check("abort_settle_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("abort_select", 32'(select), 32'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    start = done_cnt;
    repeat (12) step();
    check("abort_no_done", 32'(done_cnt), 32'(start));
    check("abort_no_launch", 32'(launch_cnt), 32'd4);
`else
    // Without sweep support sweep_start is ignored
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    check("nosweep_busy0", 32'(busy), 32'd0);
    step();
    check("nosweep_busy1", 32'(busy), 32'd0);
    check("nosweep_ready", 32'(req_ready), 32'd1);
    check("nosweep_launch", 32'(launch_cnt), 32'd0);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/cascade_tap_sequencer.md
CASCADE_TAP_SEQUENCER -- requirements
Module: cascade_tap_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles the select code is held before completion is signalled; legal range 1..255.
REQ-002 Parameter QUIET_CYCLES, default 2: consecutive low cycles of line_in required before select may change; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  tap-change request valid.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_tap  input  3  requested tap index, 0..6.
REQ-008 line_in  input  1  copy of the signal entering the delay cascade; monitored for quiet.
REQ-009 sweep_start  input  1  one-cycle pulse that starts an automatic sweep.
REQ-010 select  output  6  thermometer select for the cascade stages, registered.
REQ-011 launch  output  1  one-cycle measurement-launch pulse, used in sweep only.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  sticky flag: last accepted req_tap was greater than 6.

Function
REQ-015 The select code SHALL be thermometer-encoded: tap n maps to (1<<n)-1, so tap 0 is 0x00, tap 3 is 0x07 and tap 6 is 0x3F; no other code SHALL ever appear on select.
REQ-016 req_tap values 7 SHALL clamp to tap 6 and set err; err SHALL clear on the next accepted request with req_tap <= 6.
REQ-017 req_ready SHALL be (state==IDLE) && !rst; a request is accepted on a clock edge where req_valid && req_ready, and req_tap is latched at that edge.
REQ-018 quiet_cnt SHALL be a saturating counter that runs in every state: it resets to 0 on any cycle with line_in=1 and otherwise increments, saturating at QUIET_CYCLES.
REQ-019 State machine states: IDLE, WAIT_QUIET, APPLY, SETTLE, LAUNCH, DONE.
REQ-020 IDLE -> WAIT_QUIET on request accept or on sweep_start.
REQ-021 If sweep_start and req_valid arrive in the same cycle, sweep_start SHALL win and the request SHALL NOT be accepted.
REQ-022 WAIT_QUIET -> APPLY on the first edge at which quiet_cnt == QUIET_CYCLES; otherwise remain in WAIT_QUIET.
REQ-023 APPLY -> SETTLE: select is written on this edge and the settle counter is cleared.
REQ-024 SETTLE -> DONE (request mode) or LAUNCH (sweep mode) after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-025 LAUNCH: launch=1 for one cycle; then increment the sweep tap and go to WAIT_QUIET, or go to DONE after tap 6.
REQ-026 DONE: done=1 for one cycle; then go to IDLE.
REQ-027 Request-mode latency with line_in quiet: accept at edge E0, select updated at E2, done high between edges E(2+SETTLE_CYCLES) and E(3+SETTLE_CYCLES), req_ready high again after E(3+SETTLE_CYCLES).
REQ-028 select SHALL change only on the APPLY edge, never while line_in has been high within the last QUIET_CYCLES cycles.
REQ-029 A sweep SHALL step taps 0,1,...,6 in order, producing exactly 7 launch pulses and then one done pulse.
REQ-030 Requests arriving while busy SHALL be held off by req_ready=0 and SHALL NOT be dropped or queued internally.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL enter IDLE and set select=0x00, launch=0, done=0, err=0, busy=0 and quiet_cnt=0.
REQ-032 A reset in any state, including mid-sweep and mid-SETTLE, SHALL abort the operation with no done pulse.
REQ-033 req_ready SHALL be 0 while rst=1.

Configuration
REQ-034 Macro CASCADE_SWEEP_EN: when defined, sweep mode and the LAUNCH state are implemented.
REQ-035 When CASCADE_SWEEP_EN is undefined, sweep_start SHALL be ignored, launch SHALL be tied to 0, the LAUNCH state SHALL be absent, and the ports SHALL be unchanged.

Verification
REQ-036 Reset, then req_tap=3 with line_in=0 and SETTLE_CYCLES=4 -> select=0x07 after E2; done is a single pulse in cycle E6-E7.
REQ-037 req_tap=5 with line_in toggling until cycle 10 and low afterwards (QUIET_CYCLES=2) -> select stays at its old value until 2 low cycles have elapsed, then becomes 0x1F.
REQ-038 req_tap=7 -> select=0x3F and err=1; then req_tap=1 -> select=0x01 and err=0.
REQ-039 sweep_start with CASCADE_SWEEP_EN defined -> select follows 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F, with 7 launch pulses and then 1 done pulse; without the macro -> busy stays 0.
REQ-040 rst asserted during SETTLE of a sweep at tap 4 -> next cycle select=0x00, busy=0, and no done pulse.
REQ-041 sweep_start and req_valid asserted in the same cycle -> sweep runs; req_ready=0 until the sweep's done pulse.
